// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
package ex_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Fill bit replicated across lo on a divide by zero
    localparam logic DIV_ZERO_LO = 1'b1;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes, one quotient bit per step.
// The *_c_o outputs are the combinational result of the step taken this cycle.
module ex_div_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quo_c_o,
    output logic [DATA_W-1:0] rem_c_o
);
    localparam int unsigned EXT_W = DATA_W + 1;

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [EXT_W-1:0]  shifted;
    logic [EXT_W-1:0]  diff;
    logic              fits;

    // Partial remainder stays below the divisor, so the shifted value fits in EXT_W bits
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[DATA_W];
        rem_c_o = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_c_o = {quo_q[DATA_W-2:0], fits};
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = rem_c_o;
            quo_d = quo_c_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit beside the EX-stage ALU; writes {hi,lo} for HI/LO.
// Shift-add multiply and the control FSM live here; division uses ex_div_iter.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_annul,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_opa,
    input  logic [DATA_W-1:0] i_opb,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [DATA_W-1:0] i_lo,
    output logic              o_stall_req,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div_by_zero
);
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = DATA_W + 1;

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d, op_in;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic              dz_q, dz_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic              dbz_q, dbz_d;

    logic              start_acc, a_neg, b_neg, div_load, div_step;
    logic [DATA_W-1:0] mag_a, mag_b, quo_c, rem_c, quo_fix, rem_fix;
    logic [SUM_W-1:0]  sum;
    logic [PROD_W-1:0] prod_step, mul_mag, mul_res;

    // Request decode and operand magnitudes for capture at start
    always_comb begin
        op_in     = muldiv_op_e'(i_op);
        start_acc = (state_q == IDLE) && i_start && !i_annul;
        a_neg     = op_is_signed(op_in) && i_opa[DATA_W-1];
        b_neg     = op_is_signed(op_in) && i_opb[DATA_W-1];
        mag_a     = a_neg ? (DATA_W'(0) - i_opa) : i_opa;
        mag_b     = b_neg ? (DATA_W'(0) - i_opb) : i_opb;
    end

    // Shift-add step: multiplier sits in the low half and shifts out as the product fills in
    always_comb begin
        sum       = {1'b0, prod_q[PROD_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : SUM_W'(0));
        prod_step = {sum, prod_q[DATA_W-1:1]};
        mul_mag   = (op_is_signed(op_q) && (sa_q ^ sb_q)) ? (PROD_W'(0) - prod_step) : prod_step;
        case (op_q)
            OP_MADD: mul_res = acc_q + mul_mag;
            OP_MSUB: mul_res = acc_q - mul_mag;
            default: mul_res = mul_mag;
        endcase
        quo_fix = ((op_q == OP_DIV) && (sa_q ^ sb_q)) ? (DATA_W'(0) - quo_c) : quo_c;
        rem_fix = ((op_q == OP_DIV) && sa_q) ? (DATA_W'(0) - rem_c) : rem_c;
    end

    ex_div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_c_o    (quo_c),
        .rem_c_o    (rem_c)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opa_d    = opa_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        dz_d     = dz_q;
        valid_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    op_d     = op_in;
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    opa_d    = i_opa;
                    mcand_d  = mag_a;
                    prod_d   = {DATA_W'(0), mag_b};
                    acc_d    = {i_hi, i_lo};
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    div_load = 1'b1;
                    if (op_is_div(op_in) && (i_opb == '0)) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                prod_d   = prod_step;
                div_step = op_is_div(op_q);
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (op_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = mul_res[PROD_W-1:DATA_W];
                        lo_d = mul_res[DATA_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                dz_d    = 1'b0;
                // Divide-by-zero spends DONE as its wait cycle and reports on the way out
                if (dz_q) begin
                    valid_d = 1'b1;
                    hi_d    = opa_q;
                    lo_d    = {DATA_W{DIV_ZERO_LO}};
                    dbz_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_annul) begin
            state_d = IDLE;
            cnt_d   = '0;
            dz_d    = 1'b0;
            valid_d = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Stall must reach IF/ID/EX in the request cycle itself, so it is combinational
    assign o_stall_req   = start_acc || (state_q == BUSY) || ((state_q == DONE) && dz_q);
    assign o_valid       = valid_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (DATA_W=32): directed ops, latency, stall, annul and reset.
module tb_ex_muldiv;
    import ex_pkg::*;

    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          edge_n;
    } exp_t;

    logic        i_clk, i_rst, i_start, i_annul;
    logic [2:0]  i_op;
    logic [31:0] i_opa, i_opb, i_hi, i_lo;
    logic        o_stall_req, o_valid, o_div_by_zero;
    logic [31:0] o_hi, o_lo;

    int          cyc;
    int          total;
    int          bad;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_hi, last_lo;

    ex_muldiv #(.DATA_W(DATA_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_annul       (i_annul),
        .i_op          (i_op),
        .i_opa         (i_opa),
        .i_opb         (i_opb),
        .i_hi          (i_hi),
        .i_lo          (i_lo),
        .o_stall_req   (o_stall_req),
        .o_valid       (o_valid),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding expectation
    always @(posedge i_clk) begin
        #1;
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_valid", 64'(o_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res_hi", 64'(o_hi), 64'(mon_e.hi));
                check("res_lo", 64'(o_lo), 64'(mon_e.lo));
                check("res_dbz", 64'(o_div_by_zero), 64'(mon_e.dbz));
                check("res_latency", 64'(cyc), 64'(mon_e.edge_n));
            end
        end
    end

    // Issue one op at a negedge, scramble inputs afterwards, check stall until the result cycle
    task automatic do_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ahi, input logic [31:0] alo,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        int   lat;
        int   stall_err;
        lat     = edz ? 1 : int'(DATA_W);
        i_op    = op;
        i_opa   = a;
        i_opb   = b;
        i_hi    = ahi;
        i_lo    = alo;
        i_start = 1'b1;
        e.hi     = ehi;
        e.lo     = elo;
        e.dbz    = edz;
        e.edge_n = cyc + 1 + lat;
        sb.push_back(e);
        #1;
        check("stall_start", 64'(o_stall_req), 64'd1);
        @(negedge i_clk);
        i_start = 1'b0;
        i_op    = OP_MULTU;
        i_opa   = ~a;
        i_opb   = ~b;
        i_hi    = ~ahi;
        i_lo    = ~alo;
        stall_err = 0;
        while (cyc < e.edge_n) begin
            if (o_stall_req !== 1'b1) stall_err++;
            @(negedge i_clk);
        end
        check("stall_busy", 64'(stall_err), 64'd0);
        check("stall_valid", 64'(o_stall_req), 64'd0);
        last_hi = ehi;
        last_lo = elo;
        @(negedge i_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        total   = 0;
        bad     = 0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_annul = 1'b0;
        i_op    = OP_MULT;
        i_opa   = '0;
        i_opb   = '0;
        i_hi    = '0;
        i_lo    = '0;
        last_hi = '0;
        last_lo = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_stall", 64'(o_stall_req), 64'd0);
        check("rst_hi", 64'(o_hi), 64'd0);
        check("rst_lo", 64'(o_lo), 64'd0);
        check("rst_dbz", 64'(o_div_by_zero), 64'd0);

        do_op(OP_MULT,  32'hFFFFFFFD, 32'd7, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op(OP_MULT,  32'h80000000, 32'h80000000, '0, '0, 32'h40000000, 32'h00000000, 1'b0);
        do_op(OP_DIVU,  32'd100, 32'd7, '0, '0, 32'h00000002, 32'h0000000E, 1'b0);
        do_op(OP_DIV,   32'hFFFFFFF9, 32'd2, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op(OP_DIV,   32'd7, 32'hFFFFFFFE, '0, '0, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h00000000, 32'h80000000, 1'b0);
        do_op(OP_DIVU,  32'hFFFFFFFF, 32'd1, '0, '0, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        do_op(OP_DIV,   32'd5, 32'd0, '0, '0, 32'h00000005, 32'hFFFFFFFF, 1'b1);
        do_op(OP_MADD,  32'd2, 32'd3, 32'd0, 32'd5, 32'h00000000, 32'h0000000B, 1'b0);
        do_op(OP_MSUB,  32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op(OP_MADD,  32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000005, 1'b0);
        do_op(OP_MADD,  32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op(OP_DIVU,  32'd5, 32'd0, '0, '0, 32'h00000005, 32'hFFFFFFFF, 1'b1);

        // Start pulses while BUSY must be ignored: exactly one result appears
        i_op = OP_MULTU; i_opa = 32'd6; i_opb = 32'd7; i_start = 1'b1;
        e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0; e.edge_n = cyc + 1 + int'(DATA_W);
        sb.push_back(e);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_op = OP_DIV; i_opa = 32'd9; i_opb = 32'd0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        while (cyc < e.edge_n) @(negedge i_clk);
        repeat (6) @(negedge i_clk);
        last_hi = 32'd0;
        last_lo = 32'd42;

        // Annul in cycle T+10: no result, stall drops, previous result held, restart works
        i_op = OP_DIVU; i_opa = 32'd1000; i_opb = 32'd10; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        i_annul = 1'b1;
        @(negedge i_clk);
        i_annul = 1'b0;
        check("annul_stall", 64'(o_stall_req), 64'd0);
        check("annul_valid", 64'(o_valid), 64'd0);
        check("annul_hold", {o_hi, o_lo}, {last_hi, last_lo});
        do_op(OP_DIVU, 32'd1000, 32'd10, '0, '0, 32'h00000000, 32'h00000064, 1'b0);

        // Annul and start together: annul wins, unit stays idle
        i_op = OP_MULTU; i_opa = 32'd3; i_opb = 32'd3; i_start = 1'b1; i_annul = 1'b1;
        #1;
        check("annul_start_stall", 64'(o_stall_req), 64'd0);
        @(negedge i_clk);
        i_start = 1'b0; i_annul = 1'b0;
        check("annul_start_idle", 64'(o_stall_req), 64'd0);
        repeat (40) @(negedge i_clk);

        // Sticky div-by-zero flag, then synchronous reset mid-operation clears everything
        do_op(OP_DIV, 32'd5, 32'd0, '0, '0, 32'h00000005, 32'hFFFFFFFF, 1'b1);
        i_op = OP_MULT; i_opa = 32'hFFFFFFFD; i_opb = 32'd7; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_stall", 64'(o_stall_req), 64'd0);
        check("midrst_hi", 64'(o_hi), 64'd0);
        check("midrst_lo", 64'(o_lo), 64'd0);
        check("midrst_dbz", 64'(o_div_by_zero), 64'd0);
        repeat (40) @(negedge i_clk);

        do_op(OP_MULTU, 32'd6, 32'd7, '0, '0, 32'h00000000, 32'h0000002A, 1'b0);
        repeat (3) @(negedge i_clk);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
